// File: rtl/collision_pkg.sv
// collision_pkg: edge-code constants and types shared by the bitmap renderers
// and the hit edge collector.
//   NUM_EDGE_CODES : number of distinct hit edge codes (one mask bit each)
//   CODE_W         : width of the HitEdgeCode bus
package collision_pkg;

    localparam int unsigned NUM_EDGE_CODES = 5;
    localparam int unsigned CODE_W         = 3;

    typedef enum logic [CODE_W-1:0] {
        EDGE_BOTTOM = CODE_W'(0),
        EDGE_LEFT   = CODE_W'(1),
        EDGE_RIGHT  = CODE_W'(2),
        EDGE_TOP    = CODE_W'(3),
        EDGE_CORNER = CODE_W'(4)
    } edge_code_t;

    typedef logic [NUM_EDGE_CODES-1:0] edge_mask_t;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } collector_state_t;

endpackage

// File: rtl/hit_edge_collector_if.sv
// hit_edge_collector_if: collision event valid/ack handshake.
//   collision_valid   : event pending (producer -> consumer)
//   collision_mask    : one-hot OR of edges hit in the reported frame(s)
//   collision_overrun : a newer frame event was merged into an unacked one
//   collision_ack     : consumer takes the pending event (valid && ack = transfer)
// Modports: master = event producer (collector), slave = consumer (game control).
interface hit_edge_collector_if;
    import collision_pkg::*;

    logic       collision_valid;
    edge_mask_t collision_mask;
    logic       collision_overrun;
    logic       collision_ack;

    modport master (
        output collision_valid,
        output collision_mask,
        output collision_overrun,
        input  collision_ack
    );

    modport slave (
        input  collision_valid,
        input  collision_mask,
        input  collision_overrun,
        output collision_ack
    );

endinterface

// File: rtl/hit_code_onehot.sv
// hit_code_onehot: combinational HitEdgeCode -> one-hot edge mask decoder.
//   code   : in  CODE_W          edge code
//   onehot : out NUM_EDGE_CODES  one-hot mask; all zero for out-of-range codes
module hit_code_onehot
    import collision_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output edge_mask_t        onehot
);

    // Codes at or above NUM_EDGE_CODES match no bit and decode to zero.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_EDGE_CODES; i++) begin
            onehot[i] = (code == CODE_W'(i));
        end
    end

endmodule

// File: rtl/hit_edge_collector.sv
// hit_edge_collector: accumulates edges where the object overlaps a second drawn
// object during one video frame and publishes one collision event per frame at
// startOfFrame over a valid/ack handshake.
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   startOfFrame          : one-cycle pulse at first pixel of a frame
//   drawingRequest_obj    : object draws this pixel
//   HitEdgeCode           : edge code of that pixel
//   drawingRequest_other  : second object draws this pixel
//   evt (master)          : collision_valid/mask/overrun out, collision_ack in
//   pixel_hit             : both requests were high on the previous cycle
//   collision_count       : saturating count of frame events
// Optional feature: define HIT_COUNT_EN to build the frame-event counter;
// otherwise collision_count is tied to zero.
module hit_edge_collector
    import collision_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               drawingRequest_obj,
    input  logic [CODE_W-1:0]  HitEdgeCode,
    input  logic               drawingRequest_other,
    hit_edge_collector_if.master evt,
    output logic               pixel_hit,
    output logic [COUNT_W-1:0] collision_count
);

    logic             hit_c;
    logic             frame_event_c;
    edge_mask_t       code_mask_c;
    logic             accum_hit;
    edge_mask_t       accum_mask;
    collector_state_t state_q;
    logic             valid_q;
    edge_mask_t       mask_q;
    logic             overrun_q;

    assign hit_c         = drawingRequest_obj && drawingRequest_other;
    assign frame_event_c = startOfFrame && accum_hit;

    hit_code_onehot u_onehot (
        .code   (HitEdgeCode),
        .onehot (code_mask_c)
    );

    // Frame accumulator; a hit on the startOfFrame cycle seeds the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_hit  <= 1'b0;
            accum_hit  <= 1'b0;
            accum_mask <= '0;
        end else begin
            pixel_hit <= hit_c;
            if (startOfFrame) begin
                accum_hit  <= hit_c;
                accum_mask <= hit_c ? code_mask_c : '0;
            end else if (hit_c) begin
                accum_hit  <= 1'b1;
                accum_mask <= accum_mask | code_mask_c;
            end
        end
    end

    // Event FSM: EMPTY waits for a frame event, PENDING holds it until ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            valid_q   <= 1'b0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (frame_event_c) begin
                        valid_q <= 1'b1;
                        mask_q  <= accum_mask;
                        state_q <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_event_c && evt.collision_ack) begin
                        // Old event transfers; the new one replaces it cleanly.
                        mask_q    <= accum_mask;
                        overrun_q <= 1'b0;
                    end else if (frame_event_c) begin
                        mask_q    <= mask_q | accum_mask;
                        overrun_q <= 1'b1;
                    end else if (evt.collision_ack) begin
                        valid_q   <= 1'b0;
                        mask_q    <= '0;
                        overrun_q <= 1'b0;
                        state_q   <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q   <= ST_EMPTY;
                    valid_q   <= 1'b0;
                    mask_q    <= '0;
                    overrun_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt.collision_valid   = valid_q;
    assign evt.collision_mask    = mask_q;
    assign evt.collision_overrun = overrun_q;

`ifdef HIT_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    // Counts every frame event, merged or not; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (frame_event_c && (count_q != '1)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign collision_count = count_q;
`else
    assign collision_count = '0;
`endif

endmodule

// File: tb/tb_hit_edge_collector.sv
// tb_hit_edge_collector: directed-vector bench for hit_edge_collector.
// Build with HIT_COUNT_EN defined to exercise the counter at COUNT_W=2.
module tb_hit_edge_collector;
    import collision_pkg::*;

`ifdef HIT_COUNT_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic              clk;
    logic              reset;
    logic              startOfFrame;
    logic              drawingRequest_obj;
    logic [CODE_W-1:0] HitEdgeCode;
    logic              drawingRequest_other;
    logic              pixel_hit;
    logic [CNT_W-1:0]  collision_count;

    int unsigned n_checks;
    int unsigned n_errors;

    hit_edge_collector_if evt_if ();

    hit_edge_collector #(
        .COUNT_W (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (startOfFrame),
        .drawingRequest_obj   (drawingRequest_obj),
        .HitEdgeCode          (HitEdgeCode),
        .drawingRequest_other (drawingRequest_other),
        .evt                  (evt_if.master),
        .pixel_hit            (pixel_hit),
        .collision_count      (collision_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it in, then return idle at edge+1.
    task automatic drive(input logic sof, input logic obj, input logic other,
                         input logic [CODE_W-1:0] code, input logic ack);
        startOfFrame         = sof;
        drawingRequest_obj   = obj;
        drawingRequest_other = other;
        HitEdgeCode          = code;
        evt_if.collision_ack = ack;
        @(posedge clk);
        #1;
        startOfFrame         = 1'b0;
        drawingRequest_obj   = 1'b0;
        drawingRequest_other = 1'b0;
        HitEdgeCode          = '0;
        evt_if.collision_ack = 1'b0;
    endtask

    task automatic hit(input logic [CODE_W-1:0] code);
        drive(1'b0, 1'b1, 1'b1, code, 1'b0);
    endtask

    task automatic sof();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic ack();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [4:0] m, input logic o);
        check({tag, "_valid"},   32'(evt_if.collision_valid),   32'(v));
        check({tag, "_mask"},    32'(evt_if.collision_mask),    32'(m));
        check({tag, "_overrun"}, 32'(evt_if.collision_overrun), 32'(o));
    endtask

    task automatic check_count(input string tag, input int unsigned exp_en);
`ifdef HIT_COUNT_EN
        check(tag, 32'(collision_count), 32'(exp_en));
`else
        check(tag, 32'(collision_count), 32'(exp_en & 0));
`endif
    endtask

    initial begin
        n_checks             = 0;
        n_errors             = 0;
        reset                = 1'b1;
        startOfFrame         = 1'b0;
        drawingRequest_obj   = 1'b0;
        drawingRequest_other = 1'b0;
        HitEdgeCode          = '0;
        evt_if.collision_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_evt("rst", 1'b0, 5'b00000, 1'b0);
        check("rst_pixel_hit", 32'(pixel_hit), 32'd0);
        check_count("rst_count", 0);
        reset = 1'b0;

        // Empty frame: no event.
        sof();
        drive(1'b0, 1'b1, 1'b0, EDGE_TOP, 1'b0);
        sof();
        check_evt("empty", 1'b0, 5'b00000, 1'b0);

        // Single hit, code 3; pixel_hit one cycle late.
        hit(EDGE_TOP);
        check("pixhit_hi", 32'(pixel_hit), 32'd1);
        drive(1'b0, 1'b1, 1'b0, EDGE_BOTTOM, 1'b0);
        check("pixhit_lo", 32'(pixel_hit), 32'd0);
        sof();
        check_evt("single", 1'b1, 5'b01000, 1'b0);
        check_count("cnt1", 1);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_evt("single_hold", 1'b1, 5'b01000, 1'b0);
        ack();
        check_evt("single_ack", 1'b0, 5'b00000, 1'b0);

        // Multi-edge frame, with a non-overlapping pixel mixed in.
        hit(EDGE_LEFT);
        drive(1'b0, 1'b0, 1'b1, EDGE_BOTTOM, 1'b0);
        hit(EDGE_RIGHT);
        hit(EDGE_CORNER);
        sof();
        check_evt("multi", 1'b1, 5'b10110, 1'b0);
        check_count("cnt2", 2);
        ack();

        // Overrun: frame A unacked, frame B merges in.
        hit(EDGE_BOTTOM);
        sof();
        check_evt("ovr_a", 1'b1, 5'b00001, 1'b0);
        hit(EDGE_RIGHT);
        sof();
        check_evt("ovr_b", 1'b1, 5'b00101, 1'b1);
        check_count("cnt_sat", 3);
        ack();
        check_evt("ovr_ack", 1'b0, 5'b00000, 1'b0);

        // Ack on the same cycle as the next frame event.
        hit(EDGE_BOTTOM);
        sof();
        hit(EDGE_RIGHT);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_evt("ackcol", 1'b1, 5'b00100, 1'b0);
        ack();

        // Hit on the startOfFrame cycle belongs to the next frame.
        hit(EDGE_TOP);
        drive(1'b1, 1'b1, 1'b1, EDGE_LEFT, 1'b0);
        check_evt("bnd_a", 1'b1, 5'b01000, 1'b0);
        ack();
        sof();
        check_evt("bnd_b", 1'b1, 5'b00010, 1'b0);
        ack();

        // Out-of-range code still produces an event, with empty mask.
        hit(CODE_W'(7));
        sof();
        check_evt("oor", 1'b1, 5'b00000, 1'b0);
        ack();

        // Hitless frame leaves a pending event untouched.
        hit(EDGE_CORNER);
        sof();
        sof();
        check_evt("nohit_pend", 1'b1, 5'b10000, 1'b0);
        ack();

        // Ack while empty is ignored.
        ack();
        check_evt("ack_empty", 1'b0, 5'b00000, 1'b0);

        // Async reset while pending and mid-frame; partial frame discarded.
        hit(EDGE_LEFT);
        sof();
        hit(EDGE_RIGHT);
        #2;
        reset = 1'b1;
        #1;
        check_evt("arst", 1'b0, 5'b00000, 1'b0);
        check("arst_pixel_hit", 32'(pixel_hit), 32'd0);
        check_count("arst_count", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sof();
        check_evt("post_rst", 1'b0, 5'b00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
